vram_arbiter: RTL and testbench

- Memory-side responder for the character-fetch port of the text-mode video controller.
- Serves the controller's fixed-latency reads (addr/rd/din) and arbitrates a CPU request/acknowledge port, both onto one single-port synchronous RAM.
- Video reads always win and are never delayed.
- CPU accesses use the free cycles: the video side reads at most once per 8 pixel clocks.

---
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter.sv | 93 +++++++++
 tb/tb_vram_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: video fetch port, CPU req/ack port and
// single-port synchronous RAM port. slave = arbiter side, master = peers.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_rd;
    logic [DATA_W-1:0] vid_din;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_addr, vid_rd, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_din, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_addr, vid_rd, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_din, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: fixed-latency video reads always win, CPU req/ack uses free cycles.
// Optional VRAM_CONFLICT_STATS_EN adds a saturating video/CPU conflict counter.
module vram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic          clk_pixel,
    input  logic          reset,
    vram_arbiter_if.slave bus
`ifdef VRAM_CONFLICT_STATS_EN
    ,
    output logic [15:0]   conflict_count
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ISSUED = 1'b1
    } state_t;

    state_t            state;
    logic              vid_pend;
    logic [DATA_W-1:0] vid_hold;
    logic [DATA_W-1:0] cpu_hold;
    logic              issued_we;

    logic              cpu_issue;
    logic [ADDR_W-1:0] issue_addr;

    // Single RAM access per cycle: video first, CPU only from IDLE on a free cycle
    always_comb begin
        cpu_issue  = 1'b0;
        issue_addr = bus.vid_addr;
        if (!bus.vid_rd && (state == IDLE) && bus.cpu_req) begin
            cpu_issue  = 1'b1;
            issue_addr = bus.cpu_addr;
        end
    end

    assign bus.mem_addr  = issue_addr;
    assign bus.mem_we    = cpu_issue && bus.cpu_we && !reset;
    assign bus.mem_wdata = bus.cpu_wdata;

    // Read data is forwarded straight from the RAM in the response cycle
    assign bus.vid_din   = vid_pend ? bus.mem_rdata : vid_hold;
    assign bus.cpu_rdata = ((state == ISSUED) && !issued_we) ? bus.mem_rdata : cpu_hold;
    assign bus.cpu_ack   = (state == ISSUED) && !reset;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state     <= IDLE;
            vid_pend  <= 1'b0;
            vid_hold  <= '0;
            cpu_hold  <= '0;
            issued_we <= 1'b0;
        end else begin
            vid_pend <= bus.vid_rd;
            if (vid_pend) begin
                vid_hold <= bus.mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (cpu_issue) begin
                        state     <= ISSUED;
                        issued_we <= bus.cpu_we;
                    end
                end
                ISSUED: begin
                    // Request line is ignored here so a stale req cannot reissue
                    state <= IDLE;
                    if (!issued_we) begin
                        cpu_hold <= bus.mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VRAM_CONFLICT_STATS_EN
    logic conflict;
    assign conflict = (state == IDLE) && bus.cpu_req && bus.vid_rd;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            conflict_count <= 16'd0;
        end else if (conflict && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a rule-level reference model.
module tb_vram_arbiter;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NV     = 16;
    localparam int unsigned NRAND  = 3000;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
`ifdef VRAM_CONFLICT_STATS_EN
    logic [15:0] conflict_count;
`endif

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .bus            (bus)
`ifdef VRAM_CONFLICT_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    // Synchronous single-port RAM with a bench-side preload port
    logic [7:0]  ram [0:65535];
    logic        ld_en   = 1'b0;
    logic [15:0] ld_addr = 16'd0;
    logic [7:0]  ld_data = 8'd0;
    always @(posedge clk_pixel) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        vid_rd;
        logic [15:0] vid_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [15:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic        ack;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [7:0]  vid_din;
        logic        chk_rd;
        logic [7:0]  rdata;
        logic [15:0] conf;
    } vec_t;

    vec_t vec [NV];

    function automatic vec_t mk(input logic vr, input logic [15:0] va, input logic rq,
                                input logic we, input logic [15:0] ca, input logic [7:0] wd,
                                input logic ack, input logic mwe, input logic [15:0] ma,
                                input logic [7:0] vd, input logic crd, input logic [7:0] rd,
                                input logic [15:0] cf);
        vec_t v;
        v.vid_rd = vr; v.vid_addr = va; v.cpu_req = rq; v.cpu_we = we;
        v.cpu_addr = ca; v.cpu_wdata = wd; v.ack = ack; v.mem_we = mwe;
        v.mem_addr = ma; v.vid_din = vd; v.chk_rd = crd; v.rdata = rd; v.conf = cf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic set_in(input logic vr, input logic [15:0] va, input logic rq,
                          input logic we, input logic [15:0] ca, input logic [7:0] wd);
        bus.vid_rd    = vr;
        bus.vid_addr  = va;
        bus.cpu_req   = rq;
        bus.cpu_we    = we;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = wd;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Reference model state (rule level: grant/ack/pending-read bookkeeping)
    logic [7:0]  ref_mem [0:7];
    logic        m_grant_prev, m_grant_we, m_vid_prev;
    logic [7:0]  m_grant_rdata, m_vid_data, m_vid_last, m_cpu_last;
    logic [15:0] m_conf;

    initial begin
        logic        req_active, c_we, vr, grant, e_ack, e_we;
        logic [15:0] c_addr, va, e_addr;
        logic [7:0]  c_wd, e_vid;

        set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        load(16'hFF00, 8'h41);
        load(16'hF000, 8'h01);
        load(16'hF001, 8'h02);
        load(16'hF002, 8'h03);
        reset = 1'b0;

        // Reset state
        @(negedge clk_pixel);
        chk("reset cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("reset vid_din",   32'(bus.vid_din),   32'd0);
        chk("reset cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("reset mem_we",    32'(bus.mem_we),    32'd0);
        chk("reset mem_addr",  32'(bus.mem_addr),  32'd0);
`ifdef VRAM_CONFLICT_STATS_EN
        chk("reset conflict_count", 32'(conflict_count), 32'd0);
`endif
        tick();

        //           vr  vaddr     rq  we  caddr     wd     ack mwe maddr     vdin   crd rdata  conf
        vec[0]  = mk(1, 16'hFF00, 0, 0, 16'h0000, 8'h00, 0, 0, 16'hFF00, 8'h00, 0, 8'h00, 16'd0);
        vec[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h41, 0, 8'h00, 16'd0);
        vec[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h41, 0, 8'h00, 16'd0);
        vec[3]  = mk(0, 16'h0000, 1, 1, 16'h1234, 8'h5A, 0, 1, 16'h1234, 8'h41, 0, 8'h00, 16'd0);
        vec[4]  = mk(0, 16'h0000, 1, 1, 16'h1234, 8'h5A, 1, 0, 16'h0000, 8'h41, 1, 8'h00, 16'd0);
        vec[5]  = mk(0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 0, 16'h1234, 8'h41, 0, 8'h00, 16'd0);
        vec[6]  = mk(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h41, 1, 8'h5A, 16'd0);
        vec[7]  = mk(1, 16'hF000, 1, 0, 16'hFF00, 8'h00, 0, 0, 16'hF000, 8'h41, 0, 8'h00, 16'd0);
        vec[8]  = mk(0, 16'h0000, 1, 0, 16'hFF00, 8'h00, 0, 0, 16'hFF00, 8'h01, 0, 8'h00, 16'd1);
        vec[9]  = mk(0, 16'h0000, 1, 0, 16'hFF00, 8'h00, 1, 0, 16'h0000, 8'h01, 1, 8'h41, 16'd1);
        vec[10] = mk(1, 16'hF000, 1, 1, 16'h2000, 8'h77, 0, 0, 16'hF000, 8'h01, 0, 8'h00, 16'd1);
        vec[11] = mk(1, 16'hF001, 1, 1, 16'h2000, 8'h77, 0, 0, 16'hF001, 8'h01, 0, 8'h00, 16'd2);
        vec[12] = mk(1, 16'hF002, 1, 1, 16'h2000, 8'h77, 0, 0, 16'hF002, 8'h02, 0, 8'h00, 16'd3);
        vec[13] = mk(0, 16'h0000, 1, 1, 16'h2000, 8'h77, 0, 1, 16'h2000, 8'h03, 0, 8'h00, 16'd4);
        vec[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h03, 1, 8'h41, 16'd4);
        vec[15] = mk(0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h03, 0, 8'h00, 16'd4);

        for (int i = 0; i < int'(NV); i++) begin
            set_in(vec[i].vid_rd, vec[i].vid_addr, vec[i].cpu_req, vec[i].cpu_we,
                   vec[i].cpu_addr, vec[i].cpu_wdata);
            @(negedge clk_pixel);
            chk($sformatf("row%0d cpu_ack", i),  32'(bus.cpu_ack),  32'(vec[i].ack));
            chk($sformatf("row%0d mem_we", i),   32'(bus.mem_we),   32'(vec[i].mem_we));
            chk($sformatf("row%0d mem_addr", i), 32'(bus.mem_addr), 32'(vec[i].mem_addr));
            chk($sformatf("row%0d vid_din", i),  32'(bus.vid_din),  32'(vec[i].vid_din));
            if (vec[i].chk_rd)
                chk($sformatf("row%0d cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vec[i].rdata));
`ifdef VRAM_CONFLICT_STATS_EN
            chk($sformatf("row%0d conflict_count", i), 32'(conflict_count), 32'(vec[i].conf));
`endif
            tick();
        end

        // Held request: one access every 2 cycles, nothing issued in ack cycles
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 16'hBEEF, 1'b1, 1'b1, 16'h1111, 8'hC3);
            @(negedge clk_pixel);
            chk($sformatf("held%0d cpu_ack", i),  32'(bus.cpu_ack),  32'((i % 2) == 1));
            chk($sformatf("held%0d mem_we", i),   32'(bus.mem_we),   32'((i % 2) == 0));
            chk($sformatf("held%0d mem_addr", i), 32'(bus.mem_addr),
                ((i % 2) == 0) ? 32'h1111 : 32'hBEEF);
            tick();
        end
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk_pixel);
        chk("held_end cpu_ack", 32'(bus.cpu_ack), 32'd0);
        tick();

        // Reset while ISSUED: no ack, mem_we held low, holds cleared
        set_in(1'b0, 16'h0, 1'b1, 1'b1, 16'h3000, 8'h99);
        @(negedge clk_pixel);
        chk("rst_issue mem_we", 32'(bus.mem_we), 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk_pixel);
        chk("rst_issued cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_issued mem_we",  32'(bus.mem_we),  32'd0);
        tick();
        @(negedge clk_pixel);
        chk("rst_idle cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_idle mem_we",  32'(bus.mem_we),  32'd0);
        tick();
        reset = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
        @(negedge clk_pixel);
        chk("post_rst cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("post_rst vid_din",   32'(bus.vid_din),   32'd0);
        chk("post_rst cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
`ifdef VRAM_CONFLICT_STATS_EN
        chk("post_rst conflict_count", 32'(conflict_count), 32'd0);
`endif
        tick();

        // Reset with a video read pending
        set_in(1'b1, 16'hF002, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        set_in(1'b0, 16'hF002, 1'b0, 1'b0, 16'h0, 8'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_pixel);
        chk("vpend_rst vid_din", 32'(bus.vid_din), 32'd0);
        tick();

        // Randomized run against the reference model
        reset = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            ref_mem[k] = 8'($urandom);
            load(16'h5500 + 16'(k), ref_mem[k]);
        end
        reset = 1'b0;
        m_grant_prev = 1'b0; m_grant_we = 1'b0; m_vid_prev = 1'b0;
        m_grant_rdata = 8'h0; m_vid_data = 8'h0; m_vid_last = 8'h0; m_cpu_last = 8'h0;
        m_conf = 16'd0;
        req_active = 1'b0; c_we = 1'b0; c_addr = 16'h5500; c_wd = 8'h0;

        for (int n = 0; n < int'(NRAND); n++) begin
            if (!req_active && ($urandom_range(1, 0) == 1)) begin
                req_active = 1'b1;
                c_we   = 1'($urandom_range(1, 0));
                c_addr = 16'h5500 + 16'($urandom_range(7, 0));
                c_wd   = 8'($urandom);
            end
            vr = ($urandom_range(2, 0) == 0);
            va = 16'h5500 + 16'($urandom_range(7, 0));
            set_in(vr, va, req_active, c_we, c_addr, c_wd);

            e_ack  = m_grant_prev;
            grant  = req_active && !vr && !m_grant_prev;
            e_we   = grant && c_we;
            e_addr = (grant && !vr) ? c_addr : va;
            e_vid  = m_vid_prev ? m_vid_data : m_vid_last;

            @(negedge clk_pixel);
            chk("rand cpu_ack",  32'(bus.cpu_ack),  32'(e_ack));
            chk("rand mem_we",   32'(bus.mem_we),   32'(e_we));
            chk("rand mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("rand vid_din",  32'(bus.vid_din),  32'(e_vid));
            if (e_ack)
                chk("rand cpu_rdata", 32'(bus.cpu_rdata),
                    32'(m_grant_we ? m_cpu_last : m_grant_rdata));
`ifdef VRAM_CONFLICT_STATS_EN
            chk("rand conflict_count", 32'(conflict_count), 32'(m_conf));
            if (!m_grant_prev && req_active && vr && (m_conf != 16'hFFFF))
                m_conf = m_conf + 16'd1;
`endif
            if (m_vid_prev) m_vid_last = m_vid_data;
            if (m_grant_prev && !m_grant_we) m_cpu_last = m_grant_rdata;
            m_vid_prev = vr;
            if (vr) m_vid_data = ref_mem[va[2:0]];
            if (grant) begin
                m_grant_we = c_we;
                if (c_we) ref_mem[c_addr[2:0]] = c_wd;
                else      m_grant_rdata = ref_mem[c_addr[2:0]];
            end
            m_grant_prev = grant;
            if (e_ack) req_active = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
